// File: rtl/uart_pkg.sv
// Shared constants and state types for the Wishbone UART.
// Register indices are the value of wb.adr[2:1].
package uart_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_IDLE  = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_RX_FERR  = 4;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction
endpackage

// File: rtl/if_wb.sv
// 16-bit Wishbone bus bundle shared by the J1 interconnect and its slaves.
interface if_wb (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;

    modport master (input clk, rst, dat_s, ack, output cyc, stb, we, adr, dat_m);
    modport slave  (input clk, rst, cyc, stb, we, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign dout  = mem[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + FIFO_AW'(do_push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(do_pop);
        count_d  = count_q + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/wb_uart.sv
// Wishbone slave UART: 8N1 transmitter and receiver with 16-deep FIFOs
// and a runtime-programmable bit divisor.
module wb_uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic clk,
    input  logic rst,
    if_wb.slave  wb,
    input  logic uart_rx,
    output logic uart_tx
);
    localparam logic [15:0] DIV_RST = 16'((CLK_FREQ + BAUD / 2) / BAUD);

    logic        ack_q, ack_d;
    logic [15:0] div_q, div_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic [1:0]  sel;
    logic        bus_wr, bus_rd, status_rd;
    logic [15:0] rd_data;
    logic        unused_bus;

    logic       tx_push, tx_pop, tx_full, tx_empty, tx_idle;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_bit_end, tx_load;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        rx_bit_end, ferr_set, ovr_set;

    assign unused_bus = ^{wb.adr[15:3], wb.adr[0], wb.clk, wb.rst};

    // Bus side effects are applied in the ack cycle, while the master still holds the request.
    assign sel       = wb.adr[2:1];
    assign bus_wr    = ack_q & wb.cyc & wb.stb & wb.we;
    assign bus_rd    = ack_q & wb.cyc & wb.stb & ~wb.we;
    assign status_rd = bus_rd & (sel == REG_STATUS);
    assign tx_push   = bus_wr & (sel == REG_DATA);
    assign rx_pop    = bus_rd & (sel == REG_DATA) & ~rx_empty;
    assign tx_idle   = tx_empty & (tx_state_q == TX_IDLE);
    assign uart_tx   = tx_line_q;

    sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wb.dat_m[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        rd_data = 16'h0000;
        case (sel)
            REG_DATA:   rd_data = rx_empty ? 16'h0000 : {8'h00, rx_dout};
            REG_STATUS: begin
                rd_data[ST_RX_AVAIL] = ~rx_empty;
                rd_data[ST_TX_FULL]  = tx_full;
                rd_data[ST_TX_IDLE]  = tx_idle;
                rd_data[ST_RX_OVR]   = ovr_q;
                rd_data[ST_RX_FERR]  = ferr_q;
            end
            REG_DIV:    rd_data = div_q;
            default:    rd_data = 16'h0000;
        endcase
    end

    assign wb.dat_s = ack_q ? rd_data : 16'h0000;
    assign wb.ack   = ack_q;

    always_comb begin
        ack_d  = wb.cyc & wb.stb & ~ack_q;
        div_d  = (bus_wr && sel == REG_DIV) ? clamp_div(wb.dat_m) : div_q;
        ovr_d  = (ovr_q & ~status_rd) | ovr_set;
        ferr_d = (ferr_q & ~status_rd) | ferr_set;
    end

    // Transmitter: a byte waiting at the end of STOP starts immediately, with no idle gap.
    assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_line_d  = tx_line_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: tx_load = ~tx_empty;
            TX_START: begin
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_sh_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_bit_end) begin
                    tx_cnt_d = 16'd0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                        tx_line_d = tx_sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_bit_end) begin
                    tx_state_d = TX_IDLE;
                    tx_load    = ~tx_empty;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_dout;
            tx_div_d   = div_q;
            tx_cnt_d   = 16'd0;
            tx_line_d  = 1'b0;
            tx_state_d = TX_START;
        end
    end

    // Receiver: START checks mid-bit to reject glitches, then samples every div cycles.
    assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        ovr_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_div_d   = div_q;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                if (rx_bit_end) begin
                    rx_cnt_d = 16'd0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                if (rx_bit_end) begin
                    rx_state_d = RX_IDLE;
                    if (!rx_s2_q) begin
                        ferr_set = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                        ovr_set = rx_full & ~rx_pop;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            div_q      <= DIV_RST;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= DIV_RST;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= DIV_RST;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            div_q      <= div_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
        end
    end
endmodule
